// File: rtl/mem_sched_pkg.sv
// Shared types and defaults for the I/D memory-port scheduler.
// Holds the FSM state encoding and the line-address mask helper.
`timescale 1ns/1ps
package mem_sched_pkg;

  localparam int s_offset_default     = 5;
  localparam int s_line_default       = 8 * (2 ** s_offset_default);
  localparam int starve_limit_default = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_D  = 3'd1,
    RD_I  = 3'd2,
    WR_WB = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Clears the in-line byte offset so addresses compare at line granularity.
  function automatic logic [31:0] line_addr(input logic [31:0] addr,
                                            input int unsigned offset_bits);
    line_addr = addr & ~((32'd1 << offset_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_scheduler_wb_buffer.sv
// One-entry write-back buffer: line-aligned address, line data, valid flag,
// and line-match compares for the pending D and I request addresses.
`timescale 1ns/1ps
module wb_buffer
  import mem_sched_pkg::*;
#(
  parameter int s_offset = s_offset_default,
  parameter int s_line   = s_line_default
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [31:0]       load_addr,
  input  logic [s_line-1:0] load_data,
  input  logic [31:0]       addr_d,
  input  logic [31:0]       addr_i,
  output logic              valid,
  output logic [31:0]       addr,
  output logic [s_line-1:0] data,
  output logic              match_d,
  output logic              match_i
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= line_addr(load_addr, s_offset);
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign match_d = valid && (line_addr(addr_d, s_offset) == addr);
  assign match_i = valid && (line_addr(addr_i, s_offset) == addr);

endmodule

// File: rtl/mem_scheduler.sv
// Arbitrates one line-granular memory port between I-cache reads and D-cache
// reads/write-backs, with a one-entry write-back buffer and I starvation bound.
`timescale 1ns/1ps
module mem_scheduler
  import mem_sched_pkg::*;
#(
  parameter int s_offset     = s_offset_default,
  parameter int s_line       = s_line_default,
  parameter int STARVE_LIMIT = starve_limit_default
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic [31:0]       mem_addr_i,
  input  logic              mem_read_d,
  input  logic              mem_write_d,
  input  logic [31:0]       mem_addr_d,
  input  logic [s_line-1:0] mem_wdata_d,
  input  logic              pmem_resp,
  input  logic [s_line-1:0] pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [s_line-1:0] pmem_wdata,
  output logic              mem_resp_i,
  output logic              mem_resp_d,
  output logic [s_line-1:0] inst_rdata,
  output logic [s_line-1:0] data_rdata
);

  localparam int cnt_w = $clog2(STARVE_LIMIT + 1);

  state_e            state, state_next;
  logic [cnt_w-1:0]  starve_cnt;
  logic              starve_ok;
  logic              wb_load, wb_clear, wb_valid, match_d, match_i;
  logic [31:0]       wb_addr;
  logic [s_line-1:0] wb_data;
  logic              fast_resp_q, fast_resp_next;
  logic [s_line-1:0] fast_data_q, fast_data_next;

  wb_buffer #(.s_offset(s_offset), .s_line(s_line)) u_wb (
    .clk       (clk),
    .rst       (rst),
    .load      (wb_load),
    .clear     (wb_clear),
    .load_addr (mem_addr_d),
    .load_data (mem_wdata_d),
    .addr_d    (mem_addr_d),
    .addr_i    (mem_addr_i),
    .valid     (wb_valid),
    .addr      (wb_addr),
    .data      (wb_data),
    .match_d   (match_d),
    .match_i   (match_i)
  );

  assign starve_ok = (starve_cnt < cnt_w'(STARVE_LIMIT));

  // Requests are level valid/ready: a requester holds its request until it
  // sees its one-cycle resp, then drops it during the following RESP cycle.
  always_comb begin
    state_next     = state;
    wb_load        = 1'b0;
    wb_clear       = 1'b0;
    fast_resp_next = 1'b0;
    fast_data_next = '0;
    unique case (state)
      IDLE: begin
        if (mem_write_d && !wb_valid) begin
          wb_load        = 1'b1;
          fast_resp_next = 1'b1;
          state_next     = RESP;
        end else if (mem_read_d && match_d) begin
          fast_resp_next = 1'b1;
          fast_data_next = wb_data;
          state_next     = RESP;
        end else if (mem_read_d && (!mem_read_i || starve_ok)) begin
          state_next = RD_D;
        end else if (mem_read_i) begin
          // An I read of the buffered line must see the written data.
          state_next = match_i ? WR_WB : RD_I;
        end else if (wb_valid) begin
          state_next = WR_WB;
        end
      end
      RD_D, RD_I: if (pmem_resp) state_next = RESP;
      WR_WB: begin
        if (pmem_resp) begin
          wb_clear   = 1'b1;
          state_next = IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Buffer-served completions are registered, so they appear in the RESP cycle.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    mem_resp_i = 1'b0;
    mem_resp_d = fast_resp_q;
    inst_rdata = '0;
    data_rdata = fast_data_q;
    case (state)
      RD_D: begin
        pmem_read = 1'b1;
        pmem_addr = line_addr(mem_addr_d, s_offset);
        if (pmem_resp) begin
          mem_resp_d = 1'b1;
          data_rdata = pmem_rdata;
        end
      end
      RD_I: begin
        pmem_read = 1'b1;
        pmem_addr = line_addr(mem_addr_i, s_offset);
        if (pmem_resp) begin
          mem_resp_i = 1'b1;
          inst_rdata = pmem_rdata;
        end
      end
      WR_WB: begin
        pmem_write = 1'b1;
        pmem_addr  = wb_addr;
        pmem_wdata = wb_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      fast_resp_q <= 1'b0;
      fast_data_q <= '0;
    end else begin
      state       <= state_next;
      fast_resp_q <= fast_resp_next;
      fast_data_q <= fast_data_next;
      if (state == IDLE && state_next == RD_I)
        starve_cnt <= '0;
      else if (state == IDLE && state_next == RD_D && mem_read_i && starve_ok)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_scheduler.sv
// Directed bench for mem_scheduler: requester drivers, a latency memory model
// with an expected-access scoreboard, and hand-computed expected lines.
`timescale 1ns/1ps
module tb_mem_scheduler;

  localparam int W       = 33;
  localparam int LINE    = 256;
  localparam int MEM_LAT = 3;
  localparam int BUDGET  = 200;

  typedef struct packed {
    logic            we;
    logic [31:0]     addr;
    logic [LINE-1:0] wdata;
    logic [LINE-1:0] exp_rdata;
    logic            chk_acc;
    logic [31:0]     acc;
  } d_op_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_read_i, mem_read_d, mem_write_d;
  logic [31:0]     mem_addr_i, mem_addr_d;
  logic [LINE-1:0] mem_wdata_d;
  logic            pmem_resp;
  logic [LINE-1:0] pmem_rdata;
  logic            pmem_read, pmem_write;
  logic [31:0]     pmem_addr;
  logic [LINE-1:0] pmem_wdata;
  logic            mem_resp_i, mem_resp_d;
  logic [LINE-1:0] inst_rdata, data_rdata;

  logic [W-1:0]    exp_q[$];
  logic [LINE-1:0] exp_wd_q[$];
  d_op_t           d_ops[$];
  logic [31:0]     i_addrs[$];
  logic            d_busy = 1'b0;
  logic            i_busy = 1'b0;
  int              n_checks = 0;
  int              n_fail = 0;
  int              acc_cnt = 0;

  mem_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read_i  (mem_read_i),
    .mem_addr_i  (mem_addr_i),
    .mem_read_d  (mem_read_d),
    .mem_write_d (mem_write_d),
    .mem_addr_d  (mem_addr_d),
    .mem_wdata_d (mem_wdata_d),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_addr   (pmem_addr),
    .pmem_wdata  (pmem_wdata),
    .mem_resp_i  (mem_resp_i),
    .mem_resp_d  (mem_resp_d),
    .inst_rdata  (inst_rdata),
    .data_rdata  (data_rdata)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [LINE-1:0] got, input logic [LINE-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE-1:0] mem_line(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_5A5A}};
  endfunction

  function automatic d_op_t mk_d(input logic we, input logic [31:0] addr,
                                 input logic [LINE-1:0] wdata, input logic [LINE-1:0] exp_rdata,
                                 input logic chk_acc, input int acc);
    d_op_t op;
    op.we = we; op.addr = addr; op.wdata = wdata; op.exp_rdata = exp_rdata;
    op.chk_acc = chk_acc; op.acc = 32'(acc);
    return op;
  endfunction

  // ---------------- memory model + access scoreboard ----------------
  initial begin
    int busy;
    logic [W-1:0] e;
    logic [LINE-1:0] ewd;
    busy = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      if (rst || !(pmem_read || pmem_write)) begin
        busy = 0;
      end else begin
        busy++;
        if (busy == MEM_LAT) begin
          busy = 0;
          pmem_resp = 1'b1;
          pmem_rdata = mem_line(pmem_addr);
          acc_cnt++;
          check("pmem_excl", 256'(pmem_read & pmem_write), '0);
          check("pmem_align", 256'(pmem_addr[4:0]), '0);
          if (exp_q.size() > 0) e = exp_q.pop_front(); else e = '1;
          check("pmem_acc", 256'({pmem_write, pmem_addr}), 256'(e));
          if (pmem_write) begin
            if (exp_wd_q.size() > 0) ewd = exp_wd_q.pop_front(); else ewd = '1;
            check("pmem_wdata", pmem_wdata, ewd);
          end
        end
      end
    end
  end

  // ---------------- D requester ----------------
  initial begin
    d_op_t op;
    logic got, aborted;
    int n;
    mem_read_d = 1'b0; mem_write_d = 1'b0; mem_addr_d = '0; mem_wdata_d = '0;
    forever begin
      @(posedge clk); #1;
      while (d_ops.size() > 0) begin
        d_busy = 1'b1;
        op = d_ops.pop_front();
        mem_read_d = !op.we; mem_write_d = op.we;
        mem_addr_d = op.addr; mem_wdata_d = op.wdata;
        got = 1'b0; aborted = 1'b0; n = 0;
        while (!got && !aborted && n < BUDGET) begin
          @(negedge clk); n++;
          if (rst) aborted = 1'b1;
          else if (mem_resp_d) begin
            got = 1'b1;
            if (!op.we) check("data_rdata", data_rdata, op.exp_rdata);
            if (op.chk_acc) check("d_resp_order", 256'(acc_cnt), 256'(op.acc));
          end
        end
        if (!aborted) check("d_resp_seen", 256'(got), 256'(1));
        @(posedge clk); #1;
        mem_read_d = 1'b0; mem_write_d = 1'b0;
      end
      d_busy = 1'b0;
    end
  end

  // ---------------- I requester ----------------
  initial begin
    logic [31:0] a;
    logic got;
    int n;
    mem_read_i = 1'b0; mem_addr_i = '0;
    forever begin
      @(posedge clk); #1;
      while (i_addrs.size() > 0) begin
        i_busy = 1'b1;
        a = i_addrs.pop_front();
        mem_read_i = 1'b1; mem_addr_i = a;
        got = 1'b0; n = 0;
        while (!got && n < BUDGET) begin
          @(negedge clk); n++;
          if (mem_resp_i) begin
            got = 1'b1;
            check("inst_rdata", inst_rdata, mem_line(a & 32'hFFFF_FFE0));
          end
        end
        check("i_resp_seen", 256'(got), 256'(1));
        @(posedge clk); #1;
        mem_read_i = 1'b0;
      end
      i_busy = 1'b0;
    end
  end

  // Completion strobes must be single-cycle pulses.
  initial begin
    logic prev_d, prev_i;
    prev_d = 1'b0; prev_i = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_resp_d) check("resp_d_pulse", 256'(prev_d), '0);
      if (mem_resp_i) check("resp_i_pulse", 256'(prev_i), '0);
      prev_d = mem_resp_d; prev_i = mem_resp_i;
    end
  end

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || d_busy || i_busy || d_ops.size() != 0 ||
            i_addrs.size() != 0) && n < 400) begin
      @(negedge clk); n++;
    end
    check(tag, 256'(exp_q.size()), '0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_pmem_read(input string tag, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!pmem_read && n < 40) begin
      @(negedge clk); n++;
    end
    check(tag, 256'(pmem_addr), 256'(exp_addr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, 256'({pmem_read, pmem_write, mem_resp_i, mem_resp_d}), '0);
    check({tag, "_addr"}, 256'(pmem_addr), '0);
    check({tag, "_lines"}, pmem_wdata | inst_rdata | data_rdata, '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [LINE-1:0] d1, d2, da, db, dc;
    d1 = {8{32'h1111_2222}};
    d2 = {8{32'h3333_4444}};
    da = {8{32'hAAAA_0600}};
    db = {8{32'hBBBB_0400}};
    dc = {8{32'hCCCC_0700}};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Reset in the middle of a D read, then a fresh I read.
    d_ops.push_back(mk_d(1'b0, 32'h500, '0, '0, 1'b0, 0));
    wait_pmem_read("t1_rd_d_addr", 32'h500);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("t1_rst");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("t1_post_rst");
    exp_q.push_back({1'b0, 32'h100});
    i_addrs.push_back(32'h100);
    wait_pmem_read("t1_i_addr", 32'h100);
    wait_drain("t1_drain");

    // Simultaneous I and D reads: D first.
    exp_q.push_back({1'b0, 32'h80});
    exp_q.push_back({1'b0, 32'h40});
    i_addrs.push_back(32'h40);
    d_ops.push_back(mk_d(1'b0, 32'h80, '0, mem_line(32'h80), 1'b0, 0));
    wait_drain("t2_drain");

    // Write to an empty buffer completes without memory; read passes it.
    base = acc_cnt;
    exp_q.push_back({1'b0, 32'h300});
    exp_q.push_back({1'b1, 32'h200}); exp_wd_q.push_back(d1);
    d_ops.push_back(mk_d(1'b1, 32'h200, d1, '0, 1'b1, base));
    d_ops.push_back(mk_d(1'b0, 32'h300, '0, mem_line(32'h300), 1'b1, base + 1));
    wait_drain("t3_drain");

    // Read hitting the buffered line is forwarded, not fetched.
    base = acc_cnt;
    exp_q.push_back({1'b1, 32'h200}); exp_wd_q.push_back(d2);
    d_ops.push_back(mk_d(1'b1, 32'h200, d2, '0, 1'b1, base));
    d_ops.push_back(mk_d(1'b0, 32'h21C, '0, d2, 1'b1, base));
    wait_drain("t4_drain");

    // Starvation bound: I forced after four D grants.
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 32'h1000 + 32'(k * 32)});
    exp_q.push_back({1'b0, 32'h40});
    exp_q.push_back({1'b0, 32'h1080});
    i_addrs.push_back(32'h40);
    for (int k = 0; k < 5; k++)
      d_ops.push_back(mk_d(1'b0, 32'h1000 + 32'(k * 32), '0,
                           mem_line(32'h1000 + 32'(k * 32)), 1'b0, 0));
    wait_drain("t5_drain");

    // Write into a full buffer drains the old line before accepting.
    base = acc_cnt;
    exp_q.push_back({1'b1, 32'h600}); exp_wd_q.push_back(da);
    exp_q.push_back({1'b1, 32'h400}); exp_wd_q.push_back(db);
    d_ops.push_back(mk_d(1'b1, 32'h600, da, '0, 1'b1, base));
    d_ops.push_back(mk_d(1'b1, 32'h400, db, '0, 1'b1, base + 1));
    wait_drain("t6_drain");

    // I read of the buffered line drains the write first.
    base = acc_cnt;
    exp_q.push_back({1'b1, 32'h700}); exp_wd_q.push_back(dc);
    exp_q.push_back({1'b0, 32'h700});
    d_ops.push_back(mk_d(1'b1, 32'h700, dc, '0, 1'b1, base));
    i_addrs.push_back(32'h708);
    wait_drain("t7_drain");

    check("exp_wd_q_empty", 256'(exp_wd_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
